mux_4_1: RTL and testbench
==========================

MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 Parameter WIDTH, default 1, data width of each input and of the output; SHALL accept any value >= 1.
REQ-002 Port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst_n, input, 1 bit, reset; reset is synchronous and active-low.
REQ-004 Port i0, input, WIDTH bits, data selected when sel = 2'b00.
REQ-005 Port i1, input, WIDTH bits, data selected when sel = 2'b01.
REQ-006 Port i2, input, WIDTH bits, data selected when sel = 2'b10.
REQ-007 Port i3, input, WIDTH bits, data selected when sel = 2'b11.
REQ-008 Port sel, input, 2 bits, selects one of i0..i3.
REQ-009 Port y, output, WIDTH bits, registered selected data.

Function
REQ-010 On each rising clk edge with rst_n = 1, y SHALL load i0, i1, i2 or i3 for sel = 00, 01, 10 or 11 respectively.
REQ-011 Latency SHALL be exactly one clock cycle; y reflects the inputs and sel sampled at the preceding rising edge.
REQ-012 No combinational path SHALL exist from any input to y.
REQ-013 y SHALL hold its value between rising edges regardless of input activity.
REQ-014 A change on the selected input alone, with sel unchanged, SHALL appear on y at the next rising edge.
REQ-015 A change on a non-selected input SHALL NOT affect y.
REQ-016 Simultaneous changes of sel and data before an edge SHALL produce the newly selected input's new value at that edge.
REQ-017 Decoding SHALL be full-case over all four sel codes; no latches and no default-to-X paths.
REQ-018 Selection SHALL be bitwise-independent: each bit of y comes from the same bit position of the selected input, with no width extension or truncation.

Reset
REQ-019 When rst_n = 0 at a rising clk edge, y SHALL become all zeros, overriding REQ-010.
REQ-020 Reset SHALL have no effect between clock edges; assertion or release alone SHALL NOT change y.
REQ-021 After rst_n returns to 1, the first rising edge SHALL resume normal selection per REQ-010.
REQ-022 Reset asserted mid-operation SHALL discard the pending selection without any partial update.

Structure
REQ-023 Shared package mux_pkg SHALL hold the select codes SEL_I0 = 2'b00, SEL_I1 = 2'b01, SEL_I2 = 2'b10, SEL_I3 = 2'b11 and the default width constant.
REQ-024 The selection logic SHALL be a two-level tree of a parameterised sub-module mux_2_1 (WIDTH bits, 1-bit select): level 1 uses sel[0] on the pairs (i0, i1) and (i2, i3); level 2 uses sel[1].
REQ-025 The tree SHALL be followed by a single WIDTH-bit output register with synchronous active-low reset.

Verification
REQ-026 WIDTH = 1, rst_n = 0 for two edges, then 1 -> y = 0 during reset and after the first edge that samples reset.
REQ-027 WIDTH = 1; i0 = 1, i1 = 0, i2 = 1, i3 = 0; sel stepped 00, 01, 10, 11, each held one or more cycles -> y = 1, 0, 1, 0, each one edge after its sel.
REQ-028 sel = 10 held; i2 toggled 1 -> 0 -> 1 while i0, i1 and i3 are toggled freely -> y follows only i2, one cycle late.
REQ-029 sel = 11, y = 0 with i3 = 0; rst_n pulsed low for one edge while i3 = 1 -> y = 0 at that edge, y = 1 at the next edge.
REQ-030 WIDTH = 8; i0 = 8'hA5, i1 = 8'h3C, i2 = 8'hFF, i3 = 8'h00; sel walked 11, 10, 01, 00 -> y = 00, FF, 3C, A5, each with one-cycle latency.
REQ-031 Randomised inputs over 1000 cycles against a reference model of one-cycle-delayed selection -> zero mismatches.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select codes and width default for the 4:1 mux slice.
// Imported by the mux tree and by anything that drives sel.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 1;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4_1_if.sv
// Data/select bundle for the registered 4:1 mux.
// master drives data and sel, slave returns the registered y.
interface mux_4_1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;

  modport master (
    output i0, i1, i2, i3, sel,
    input  y
  );

  modport slave (
    input  i0, i1, i2, i3, sel,
    output y
  );

endinterface

// File: rtl/mux_2_1.sv
// Parameterised 2:1 leaf used to build the 4:1 select tree.
// Purely combinational; b wins when s is high.
module mux_2_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_4_1.sv
// Registered 4:1 mux: two-level 2:1 tree into one output register.
// y updates one cycle after sel/data are sampled; sync active-low reset.
module mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] d;

  // sel[0] picks within each pair, sel[1] picks the pair
  mux_2_1 #(.WIDTH(WIDTH)) u_lo (
    .a (i0),
    .b (i1),
    .s (sel[0]),
    .y (lo)
  );

  mux_2_1 #(.WIDTH(WIDTH)) u_hi (
    .a (i2),
    .b (i3),
    .s (sel[0]),
    .y (hi)
  );

  mux_2_1 #(.WIDTH(WIDTH)) u_top (
    .a (lo),
    .b (hi),
    .s (sel[1]),
    .y (d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) y <= '0;
    else        y <= d;
  end

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1 at WIDTH 1 and 8.
// Expected y comes from an array-indexed model delayed one edge.
module tb_mux_4_1;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  mux_4_1_if #(.WIDTH(1)) b1 ();
  mux_4_1_if #(.WIDTH(8)) b8 ();

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (b1.i0),
    .i1    (b1.i1),
    .i2    (b1.i2),
    .i3    (b1.i3),
    .sel   (b1.sel),
    .y     (b1.y)
  );

  mux_4_1 #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (b8.i0),
    .i1    (b8.i1),
    .i2    (b8.i2),
    .i3    (b8.i3),
    .sel   (b8.sel),
    .y     (b8.y)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s,
                                      input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] c,
                                      input logic [7:0] d);
    logic [7:0] v [4];
    v[0] = a;
    v[1] = b;
    v[2] = c;
    v[3] = d;
    return v[s];
  endfunction

  logic [7:0] e1;
  logic [7:0] e8;

  // model the edge: compute from what is driven now, check after edge
  task automatic step(input string tag);
    logic [7:0] n1;
    logic [7:0] n8;
    n1 = rst_n ? pick(b1.sel, {7'b0, b1.i0}, {7'b0, b1.i1},
                      {7'b0, b1.i2}, {7'b0, b1.i3}) : 8'h00;
    n8 = rst_n ? pick(b8.sel, b8.i0, b8.i1, b8.i2, b8.i3) : 8'h00;
    @(posedge clk);
    #1;
    e1 = n1;
    e8 = n8;
    chk({tag, "_w1"}, {7'b0, b1.y}, e1);
    chk({tag, "_w8"}, b8.y, e8);
  endtask

  task automatic drive1(input logic [1:0] s,
                        input logic a, input logic b,
                        input logic c, input logic d);
    b1.sel = s;
    b1.i0 = a;
    b1.i1 = b;
    b1.i2 = c;
    b1.i3 = d;
  endtask

  task automatic drive8(input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    b8.sel = s;
    b8.i0 = a;
    b8.i1 = b;
    b8.i2 = c;
    b8.i3 = d;
  endtask

  initial begin
    logic [1:0] s1 [4];
    logic [1:0] s8 [4];
    logic       t2 [3];
    s1[0] = SEL_I0; s1[1] = SEL_I1; s1[2] = SEL_I2; s1[3] = SEL_I3;
    s8[0] = SEL_I3; s8[1] = SEL_I2; s8[2] = SEL_I1; s8[3] = SEL_I0;
    t2[0] = 1'b1; t2[1] = 1'b0; t2[2] = 1'b1;

    drive1(SEL_I0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive8(SEL_I2, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    rst_n = 1'b0;
    step("rst0");
    step("rst1");

    // release between edges must not move y
    rst_n = 1'b1;
    #2;
    chk("rel_hold_w1", {7'b0, b1.y}, 8'h00);
    chk("rel_hold_w8", b8.y, 8'h00);

    // fixed pattern sweeps, each sel held two edges
    for (int k = 0; k < 4; k++) begin
      drive1(s1[k], 1'b1, 1'b0, 1'b1, 1'b0);
      drive8(s8[k], 8'hA5, 8'h3C, 8'hFF, 8'h00);
      step("walk_a");
      step("walk_b");
    end

    // assertion between edges must not move y
    rst_n = 1'b0;
    #2;
    chk("asrt_hold_w8", b8.y, e8);
    rst_n = 1'b1;

    // only the selected input reaches y
    for (int k = 0; k < 3; k++) begin
      drive1(SEL_I2, 1'($urandom), 1'($urandom), t2[k], 1'($urandom));
      drive8(SEL_I2, 8'($urandom), 8'($urandom),
             t2[k] ? 8'h5A : 8'hC3, 8'($urandom));
      step("sel2_tog");
    end

    // one-edge reset pulse discards a pending selection
    drive1(SEL_I3, 1'b1, 1'b1, 1'b1, 1'b0);
    drive8(SEL_I3, 8'h11, 8'h22, 8'h33, 8'h00);
    step("pre_pulse");
    b1.i3 = 1'b1;
    b8.i3 = 8'h96;
    rst_n = 1'b0;
    step("pulse");
    rst_n = 1'b1;
    step("post_pulse");

    // sel and data change together
    drive1(SEL_I1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive8(SEL_I0, 8'h7E, 8'h01, 8'h02, 8'h03);
    step("swap");

    for (int n = 0; n < 1000; n++) begin
      rst_n = ($urandom_range(31) != 0);
      drive1(2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
      drive8(2'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
